// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill path.
// Holds the refill FSM encoding and line-geometry helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT
    } refill_state_t;

    localparam int MISS_CNT_W = 16;

    // Byte-offset bits covering one cache line of 32-bit words.
    function automatic int line_off(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer.
// Miss -> bus request -> beat stream into data array -> one-cycle tag commit.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [ADDR_W-1:0]                 pc_f_i,
    input  logic                              ic_hit_i,
    output logic                              mem_req_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    output logic                              ic_data_we_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] ic_word_sel_o,
    output logic [DATA_W-1:0]                 ic_wdata_o,
    output logic [ADDR_W-1:0]                 ic_fill_addr_o,
    output logic                              ic_repl_permit_o,
    output logic                              instr_hit_f_o,
    output logic [MISS_CNT_W-1:0]             miss_cnt_o
);

    localparam int OFF = line_off(WORDS_PER_LINE);
    localparam int CW  = $clog2(WORDS_PER_LINE);

    localparam logic [CW-1:0]     LAST     = CW'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

    refill_state_t state;
    refill_state_t state_nxt;

    logic [CW-1:0]         count;
    logic [ADDR_W-1:0]     line_addr;
    logic [MISS_CNT_W-1:0] miss_cnt;

    logic miss;
    logic beat;

    assign miss = (state == IDLE) && !ic_hit_i;
    assign beat = (state == FILL) && mem_rvalid_i;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: the line is always completed, even if fetch redirects.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (!ic_hit_i) state_nxt = REQ;
            REQ:    if (mem_gnt_i) state_nxt = FILL;
            FILL:   if (mem_rvalid_i && count == LAST) state_nxt = COMMIT;
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes: fetch only sees a valid word while idle.
    always_comb begin
        mem_req_o        = 1'b0;
        ic_data_we_o     = 1'b0;
        ic_repl_permit_o = 1'b0;
        instr_hit_f_o    = 1'b0;
        unique case (state)
            IDLE:   instr_hit_f_o    = ic_hit_i;
            REQ:    mem_req_o        = 1'b1;
            FILL:   ic_data_we_o     = mem_rvalid_i;
            COMMIT: ic_repl_permit_o = 1'b1;
            default: ;
        endcase
    end

    // Line address, beat index and saturating miss counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count     <= '0;
            line_addr <= '0;
            miss_cnt  <= '0;
        end else begin
            if (miss) begin
                line_addr <= pc_f_i & ~OFF_MASK;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
            if (state == REQ && mem_gnt_i) begin
                count <= '0;
            end else if (beat) begin
                count <= count + 1'b1;
            end else if (state == COMMIT) begin
                count <= '0;
            end
        end
    end

    assign mem_addr_o     = line_addr;
    assign ic_fill_addr_o = line_addr;
    assign ic_word_sel_o  = count;
    assign ic_wdata_o     = mem_rdata_i;
    assign miss_cnt_o     = miss_cnt;

    // Beats while a request is outstanding or committing are a bus
    // protocol error; beats in IDLE are legal leftovers of a reset burst.
    a_rvalid_in_fill : assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_rvalid_i && (state == REQ || state == COMMIT)))
        else $error("rvalid outside FILL");

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed testbench for icache_refill_ctrl.
// Linear stimulus with hand-computed expectations checked by immediate assertions.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] pc_f_i;
    logic        ic_hit_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        ic_data_we_o;
    logic [1:0]  ic_word_sel_o;
    logic [31:0] ic_wdata_o;
    logic [31:0] ic_fill_addr_o;
    logic        ic_repl_permit_o;
    logic        instr_hit_f_o;
    logic [15:0] miss_cnt_o;

    int tests  = 0;
    int failed = 0;
    int low    = 0;
    int writes = 0;
    int w      = 0;
    int pat [6] = '{1, 0, 1, 0, 1, 1};

    icache_refill_ctrl #(
        .WORDS_PER_LINE(4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .pc_f_i(pc_f_i),
        .ic_hit_i(ic_hit_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .ic_data_we_o(ic_data_we_o),
        .ic_word_sel_o(ic_word_sel_o),
        .ic_wdata_o(ic_wdata_o),
        .ic_fill_addr_o(ic_fill_addr_o),
        .ic_repl_permit_o(ic_repl_permit_o),
        .instr_hit_f_o(instr_hit_f_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1: reset state
        reset_i      = 1'b1;
        pc_f_i       = 32'h100;
        ic_hit_i     = 1'b1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        #3;
        chk("rst_hit", 32'(instr_hit_f_o), 32'd1);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_cnt", 32'(miss_cnt_o), 32'd0);
        chk("rst_we", 32'(ic_data_we_o), 32'd0);
        chk("rst_permit", 32'(ic_repl_permit_o), 32'd0);
        tick();
        reset_i = 1'b0;
        tick();

        // 2: zero-wait refill of 0x1234
        low      = 0;
        pc_f_i   = 32'h1234;
        ic_hit_i = 1'b0;
        #1;
        chk("t2_miss_hit", 32'(instr_hit_f_o), 32'd0);
        if (!instr_hit_f_o) low++;
        tick();
        ic_hit_i  = 1'b1;
        mem_gnt_i = 1'b1;
        #1;
        chk("t2_req", 32'(mem_req_o), 32'd1);
        chk("t2_addr", mem_addr_o, 32'h1230);
        chk("t2_req_hit", 32'(instr_hit_f_o), 32'd0);
        chk("t2_cnt", 32'(miss_cnt_o), 32'd1);
        if (!instr_hit_f_o) low++;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hA0 + 32'(i);
            #1;
            chk("t2_we", 32'(ic_data_we_o), 32'd1);
            chk("t2_sel", 32'(ic_word_sel_o), 32'(i));
            chk("t2_wdata", ic_wdata_o, 32'hA0 + 32'(i));
            chk("t2_req_fill", 32'(mem_req_o), 32'd0);
            if (!instr_hit_f_o) low++;
            tick();
        end
        mem_rvalid_i = 1'b0;
        #1;
        chk("t2_permit", 32'(ic_repl_permit_o), 32'd1);
        chk("t2_fill_addr", ic_fill_addr_o, 32'h1230);
        chk("t2_commit_we", 32'(ic_data_we_o), 32'd0);
        if (!instr_hit_f_o) low++;
        tick();
        chk("t2_hit_back", 32'(instr_hit_f_o), 32'd1);
        chk("t2_permit_off", 32'(ic_repl_permit_o), 32'd0);
        chk("t2_low_cycles", 32'(low), 32'd7);

        // 3: delayed grant, gapped beats
        pc_f_i   = 32'h4008;
        ic_hit_i = 1'b0;
        tick();
        ic_hit_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_req_hold", 32'(mem_req_o), 32'd1);
            chk("t3_addr_hold", mem_addr_o, 32'h4000);
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_req_gnt", 32'(mem_req_o), 32'd1);
        tick();
        mem_gnt_i = 1'b0;
        writes    = 0;
        w         = 0;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid_i = pat[i][0];
            mem_rdata_i  = 32'hB0 + 32'(w);
            #1;
            chk("t3_we", 32'(ic_data_we_o), 32'(pat[i]));
            if (pat[i] != 0) begin
                chk("t3_sel", 32'(ic_word_sel_o), 32'(w));
                chk("t3_wdata", ic_wdata_o, 32'hB0 + 32'(w));
            end
            if (ic_data_we_o) writes++;
            tick();
            if (pat[i] != 0) w++;
        end
        mem_rvalid_i = 1'b0;
        #1;
        chk("t3_writes", 32'(writes), 32'd4);
        chk("t3_permit", 32'(ic_repl_permit_o), 32'd1);
        chk("t3_fill_addr", ic_fill_addr_o, 32'h4000);
        chk("t3_cnt", 32'(miss_cnt_o), 32'd2);
        tick();

        // 4: reset mid-FILL, stray beats afterwards
        pc_f_i   = 32'h5000;
        ic_hit_i = 1'b0;
        tick();
        ic_hit_i  = 1'b1;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hC0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        reset_i      = 1'b1;
        #1;
        chk("t4_state_rst", 32'(dut.state), 32'(IDLE));
        chk("t4_cnt_rst", 32'(miss_cnt_o), 32'd0);
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hC2 + 32'(i);
            #1;
            chk("t4_state", 32'(dut.state), 32'(IDLE));
            chk("t4_we", 32'(ic_data_we_o), 32'd0);
            chk("t4_permit", 32'(ic_repl_permit_o), 32'd0);
            chk("t4_req", 32'(mem_req_o), 32'd0);
            tick();
        end
        mem_rvalid_i = 1'b0;

        // 5: redirect mid-FILL still commits the old line
        pc_f_i   = 32'h2000;
        ic_hit_i = 1'b0;
        tick();
        ic_hit_i  = 1'b1;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                pc_f_i   = 32'h3000;
                ic_hit_i = 1'b0;
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hD0 + 32'(i);
            #1;
            chk("t5_sel", 32'(ic_word_sel_o), 32'(i));
            chk("t5_hit_low", 32'(instr_hit_f_o), 32'd0);
            tick();
        end
        mem_rvalid_i = 1'b0;
        #1;
        chk("t5_permit", 32'(ic_repl_permit_o), 32'd1);
        chk("t5_fill_addr", ic_fill_addr_o, 32'h2000);
        tick();
        chk("t5_idle_req", 32'(mem_req_o), 32'd0);
        chk("t5_idle_hit", 32'(instr_hit_f_o), 32'd0);
        tick();
        ic_hit_i  = 1'b1;
        mem_gnt_i = 1'b1;
        #1;
        chk("t5_req2", 32'(mem_req_o), 32'd1);
        chk("t5_addr2", mem_addr_o, 32'h3000);
        chk("t5_cnt", 32'(miss_cnt_o), 32'd2);
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hE0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        #1;
        chk("t5_fill_addr2", ic_fill_addr_o, 32'h3000);
        tick();

        // 6: miss counter saturation
        force dut.miss_cnt = 16'hFFFE;
        #1;
        release dut.miss_cnt;
        #1;
        chk("t6_preload", 32'(miss_cnt_o), 32'h0000FFFE);
        for (int m = 0; m < 2; m++) begin
            pc_f_i   = 32'h6000 + 32'(m) * 32'h1000;
            ic_hit_i = 1'b0;
            tick();
            ic_hit_i  = 1'b1;
            mem_gnt_i = 1'b1;
            #1;
            chk("t6_sat", 32'(miss_cnt_o), 32'h0000FFFF);
            tick();
            mem_gnt_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hF0 + 32'(i);
                tick();
            end
            mem_rvalid_i = 1'b0;
            tick();
        end
        chk("t6_stay", 32'(miss_cnt_o), 32'h0000FFFF);
        chk("t6_idle_hit", 32'(instr_hit_f_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
